// File: rtl/nts_pkg.sv
// Shared types and helpers for the NTS TX path: FSM encoding, buffered word format,
// byte-mask and round-robin grant functions.
package nts_pkg;

  localparam int BYTES_PER_WORD = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_RELEASE,
    ST_COOLDOWN
  } tx_state_t;

  typedef struct packed {
    logic [8*BYTES_PER_WORD-1:0] data;
    logic [BYTES_PER_WORD-1:0]   mask;
    logic                        last;
  } tx_word_t;

  // Byte count of the final word to an MSB-aligned byte mask; 0 means a full word.
  function automatic logic [7:0] bytes_to_mask(input logic [3:0] n);
    logic [7:0] m;
    if (n == 4'd0 || n >= 4'd8) m = 8'hFF;
    else m = 8'hFF << (4'd8 - n);
    return m;
  endfunction

  // First requester found searching upward from last+1, wrapping at engines.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last,
                                         input int engines);
    logic [3:0] g;
    logic       found;
    int         idx;
    g     = last;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = (int'(last) + i) % engines;
      if (!found && i <= engines && req[idx[3:0]]) begin
        g     = idx[3:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/nts_tx_word_buffer.sv
// Small FIFO of {data, mask, last} words feeding the MAC; head word is registered storage,
// held stable while valid && !ready. Synchronous flush on reset.
module nts_tx_word_buffer
  import nts_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_areset,
  input  logic                   push,
  input  tx_word_t               push_word,
  input  logic                   ready,
  output logic                   valid,
  output tx_word_t               out_word,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);

  tx_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;

  assign valid    = (occupancy != '0);
  assign pop      = valid && ready;
  assign out_word = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

endmodule

// File: rtl/nts_tx_arbiter.sv
// Round-robin drain of engine TX FIFOs onto one MAC word stream, whole packets only; first word
// 3 cycles after grant, rd_en throttled by buffer space. Counters built only with NTS_TX_ARBITER_STATS_EN.
module nts_tx_arbiter
  import nts_pkg::*;
#(
  parameter int ENGINES        = 4,
  parameter int MAC_DATA_WIDTH = 64,
  parameter int BUF_DEPTH      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_areset,
  input  logic [ENGINES-1:0]          i_engine_packet_available,
  output logic [ENGINES-1:0]          o_engine_packet_read,
  input  logic [ENGINES-1:0]          i_engine_fifo_empty,
  output logic [ENGINES-1:0]          o_engine_fifo_rd_en,
  input  logic [MAC_DATA_WIDTH*ENGINES-1:0] i_engine_fifo_rd_data,
  input  logic [4*ENGINES-1:0]        i_engine_bytes_last_word,
  output logic                        o_mac_tx_valid,
  input  logic                        i_mac_tx_ready,
  output logic [63:0]                 o_mac_tx_data,
  output logic [7:0]                  o_mac_tx_data_valid,
  output logic                        o_mac_tx_last,
  output logic                        o_busy,
  output logic [31:0]                 o_packets_sent,
  output logic [15:0]                 o_empty_drops
);
  localparam int SEL_W = (ENGINES > 1) ? $clog2(ENGINES) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

  tx_state_t                 state_q, state_d;
  logic [SEL_W-1:0]          sel, last_grant, grant;
  logic                      inflight, rd_en, push, push_last, empty_sel;
  logic [OCC_W-1:0]          occupancy;
  logic [MAC_DATA_WIDTH-1:0] rd_word;
  logic [3:0]                sel_bytes;
  logic [ENGINES-1:0]        sel_onehot;
  tx_word_t                  push_word, out_word;

  always_comb begin
    rd_word    = '0;
    sel_bytes  = '0;
    sel_onehot = '0;
    for (int n = 0; n < ENGINES; n++) begin
      if (SEL_W'(n) == sel) begin
        rd_word       = i_engine_fifo_rd_data[n*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
        sel_bytes     = i_engine_bytes_last_word[n*4 +: 4];
        sel_onehot[n] = 1'b1;
      end
    end
  end

  assign empty_sel = i_engine_fifo_empty[sel];
  assign grant     = SEL_W'(rr_next(16'(i_engine_packet_available), 4'(last_grant), ENGINES));

  // The empty flag on a data cycle tells whether the word just returned was the packet's last.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      ST_IDLE: if (|i_engine_packet_available) state_d = ST_READ;
      ST_READ: begin
        rd_en = !empty_sel && ((32'(occupancy) + 32'(inflight)) < 32'(BUF_DEPTH));
        if (inflight) begin
          push = 1'b1;
          if (empty_sel) begin
            push_last = 1'b1;
            state_d   = ST_DRAIN;
          end
        end else if (empty_sel) begin
          state_d = ST_RELEASE;
        end
      end
      ST_DRAIN:    if (occupancy == '0) state_d = ST_RELEASE;
      ST_RELEASE:  state_d = ST_COOLDOWN;
      ST_COOLDOWN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_q    <= ST_IDLE;
      sel        <= '0;
      last_grant <= SEL_W'(ENGINES - 1);
      inflight   <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= rd_en;
      if (state_q == ST_IDLE && |i_engine_packet_available) begin
        sel        <= grant;
        last_grant <= grant;
      end
    end
  end

  assign push_word.data = rd_word;
  assign push_word.mask = push_last ? bytes_to_mask(sel_bytes) : 8'hFF;
  assign push_word.last = push_last;

  nts_tx_word_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .i_clk     (i_clk),
    .i_areset  (i_areset),
    .push      (push),
    .push_word (push_word),
    .ready     (i_mac_tx_ready),
    .valid     (o_mac_tx_valid),
    .out_word  (out_word),
    .occupancy (occupancy)
  );

  assign o_mac_tx_data        = out_word.data;
  assign o_mac_tx_data_valid  = out_word.mask;
  assign o_mac_tx_last        = out_word.last;
  assign o_engine_fifo_rd_en  = rd_en ? sel_onehot : '0;
  assign o_engine_packet_read = (state_q == ST_RELEASE) ? sel_onehot : '0;
  assign o_busy               = (state_q != ST_IDLE);

`ifdef NTS_TX_ARBITER_STATS_EN
  logic [31:0] sent_q;
  logic [15:0] drops_q;
  logic        drop;

  assign drop = (state_q == ST_READ) && !inflight && empty_sel;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      sent_q  <= '0;
      drops_q <= '0;
    end else begin
      if (state_q == ST_RELEASE && sent_q != '1) sent_q <= sent_q + 32'd1;
      if (drop && drops_q != '1) drops_q <= drops_q + 16'd1;
    end
  end

  assign o_packets_sent = sent_q;
  assign o_empty_drops  = drops_q;
`else
  assign o_packets_sent = '0;
  assign o_empty_drops  = '0;
`endif

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Bench for nts_tx_arbiter: engine FIFO model, MAC-side scoreboard, table of packets plus
// hand-timed sequences for latency, stall, empty packet and mid-packet reset.
module tb_nts_tx_arbiter;
  localparam int ENG = 4;

`ifdef NTS_TX_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset;
  logic [ENG-1:0]    avail, pkt_read, empty, rd_en;
  logic [64*ENG-1:0] rd_data;
  logic [4*ENG-1:0]  blw;
  logic              tx_valid, tx_ready, tx_last, busy;
  logic [63:0]       tx_data;
  logic [7:0]        tx_mask;
  logic [31:0]       sent;
  logic [15:0]       drops;

  nts_tx_arbiter #(.ENGINES(ENG), .MAC_DATA_WIDTH(64), .BUF_DEPTH(4)) dut (
    .i_clk                     (clk),
    .i_areset                  (areset),
    .i_engine_packet_available (avail),
    .o_engine_packet_read      (pkt_read),
    .i_engine_fifo_empty       (empty),
    .o_engine_fifo_rd_en       (rd_en),
    .i_engine_fifo_rd_data     (rd_data),
    .i_engine_bytes_last_word  (blw),
    .o_mac_tx_valid            (tx_valid),
    .i_mac_tx_ready            (tx_ready),
    .o_mac_tx_data             (tx_data),
    .o_mac_tx_data_valid       (tx_mask),
    .o_mac_tx_last             (tx_last),
    .o_busy                    (busy),
    .o_packets_sent            (sent),
    .o_empty_drops             (drops)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last;
  } exp_t;

  typedef struct {
    int         eng;
    int         nw;
    logic [3:0] b;
    logic [7:0] m;
  } vec_t;

  exp_t        sb[$];
  logic [63:0] eng_q[ENG][$];
  int          pr_q[$];
  int          checks = 0, passed = 0;
  int          accepted = 0, reads = 0, max_out = 0;
  int          ready_mode = 0;
  int          tag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic load(input int eng, input int nw, input logic [3:0] b, input logic [7:0] m);
    logic [63:0] w;
    exp_t        e;
    for (int i = 0; i < nw; i++) begin
      w = {8'(eng), 8'(tag), 16'(i), 32'hC0DE_0000 | 32'(i)};
      eng_q[eng].push_back(w);
      e.data = w;
      e.mask = (i == nw - 1) ? m : 8'hFF;
      e.last = (i == nw - 1);
      sb.push_back(e);
    end
    tag++;
    blw[eng*4 +: 4] = b;
    avail[eng]      = 1'b1;
    if (nw > 0) empty[eng] = 1'b0;
  endtask

  task automatic wait_pr(input int eng, input string name);
    int n;
    n = 0;
    while (pr_q.size() == 0 && n < 300) begin
      step();
      n++;
    end
    if (pr_q.size() == 0) begin
      checks++;
      $display("FAIL %s: no packet_read within 300 cycles, expected engine %0d", name, eng);
    end else begin
      chk(name, 64'(pr_q.pop_front()), 64'(eng));
    end
  endtask

  // Engine FIFO model: data and empty flag change on the cycle after rd_en.
  initial begin
    logic [ENG-1:0] pend;
    pend = '0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < ENG; n++) begin
        if (pend[n]) begin
          if (eng_q[n].size() > 0) begin
            rd_data[n*64 +: 64] = eng_q[n].pop_front();
          end else begin
            checks++;
            $display("FAIL rd_en_on_empty: engine %0d read with empty FIFO, expected no read", n);
          end
        end
        empty[n] = (eng_q[n].size() == 0);
      end
      #1;
      pend = rd_en;
      for (int n = 0; n < ENG; n++) begin
        if (rd_en[n]) begin
          reads++;
          if (reads - accepted > max_out) max_out = reads - accepted;
        end
        if (pkt_read[n]) avail[n] = 1'b0;
      end
    end
  end

  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = (k % 3 == 0);
          k++;
        end
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // MAC-side monitor and scoreboard.
  initial begin
    logic pv, prdy;
    exp_t prev, e;
    pv = 1'b0;
    prdy = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (pv && !prdy && tx_valid) begin
        chk("hold_data", tx_data, prev.data);
        chk("hold_mask", 64'(tx_mask), 64'(prev.mask));
        chk("hold_last", 64'(tx_last), 64'(prev.last));
      end
      if (tx_valid && tx_ready) begin
        accepted++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h expected no word", tx_data);
        end else begin
          e = sb.pop_front();
          chk("word_data", tx_data, e.data);
          chk("word_mask", 64'(tx_mask), 64'(e.mask));
          chk("word_last", 64'(tx_last), 64'(e.last));
        end
      end
      for (int n = 0; n < ENG; n++) if (pkt_read[n]) pr_q.push_back(n);
      pv     = tx_valid;
      prdy   = tx_ready;
      prev.data = tx_data;
      prev.mask = tx_mask;
      prev.last = tx_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   acc0, n;
    tbl[0] = '{1, 2, 4'd5, 8'hF8};
    tbl[1] = '{3, 1, 4'd0, 8'hFF};
    tbl[2] = '{0, 4, 4'd8, 8'hFF};
    tbl[3] = '{2, 3, 4'd1, 8'h80};
    tbl[4] = '{1, 1, 4'd7, 8'hFE};
    tbl[5] = '{0, 2, 4'd3, 8'hE0};
    tbl[6] = '{3, 5, 4'd2, 8'hC0};
    tbl[7] = '{2, 1, 4'd6, 8'hFC};
    tbl[8] = '{1, 3, 4'd4, 8'hF0};
    tbl[9] = '{0, 2, 4'd1, 8'h80};

    areset   = 1'b1;
    avail    = '0;
    empty    = '1;
    rd_data  = '0;
    blw      = '0;
    tx_ready = 1'b1;

    // Reset state.
    step(); step(); step();
    chk("rst_ctrl", {61'd0, tx_valid, tx_last, busy}, 64'd0);
    chk("rst_data", tx_data, 64'd0);
    chk("rst_mask", 64'(tx_mask), 64'd0);
    chk("rst_strobes", {56'd0, rd_en, pkt_read}, 64'd0);
    chk("rst_counters", {sent, drops, 16'd0}, 64'd0);
    @(negedge clk);
    areset = 1'b0;
    #3;
    step();

    // Engine 2 alone: 3 words, 4 valid bytes in the last.
    @(negedge clk);
    load(2, 3, 4'd4, 8'hF0);
    #3;
    step();
    chk("t1_rd_en_c1", 64'(rd_en), 64'h4);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    step();
    chk("t1_valid_c2", 64'(tx_valid), 64'd0);
    step();
    chk("t1_valid_c3", 64'(tx_valid), 64'd1);
    step(); step();
    chk("t1_last_c5", {62'd0, tx_valid, tx_last}, 64'd3);
    step();
    chk("t1_pread_c6", 64'(pkt_read), 64'd0);
    step();
    chk("t1_pread_c7", 64'(pkt_read), 64'h4);
    step();
    chk("t1_sent", 64'(sent), STATS ? 64'd1 : 64'd0);
    pr_q.delete();

    // All four engines request: order 0,1,2,3 after reset, then 0 again.
    @(negedge clk);
    areset = 1'b1;
    #3;
    step();
    @(negedge clk);
    areset = 1'b0;
    load(0, 1, 4'd1, 8'h80);
    load(1, 1, 4'd2, 8'hC0);
    load(2, 1, 4'd3, 8'hE0);
    load(3, 1, 4'd0, 8'hFF);
    #3;
    wait_pr(0, "t2_grant0");
    wait_pr(1, "t2_grant1");
    wait_pr(2, "t2_grant2");
    wait_pr(3, "t2_grant3");
    step(); step();
    @(negedge clk);
    load(0, 2, 4'd7, 8'hFE);
    #3;
    wait_pr(0, "t2_regrant0");
    chk("t2_sb_drained", 64'(sb.size()), 64'd0);

    // 5-word packet with a stalling MAC.
    step(); step();
    reads = 0;
    accepted = 0;
    max_out = 0;
    @(negedge clk);
    ready_mode = 1;
    load(3, 5, 4'd6, 8'hFC);
    #3;
    wait_pr(3, "t3_grant3");
    chk("t3_outstanding_le4", 64'(max_out <= 4), 64'd1);
    chk("t3_sb_drained", 64'(sb.size()), 64'd0);
    ready_mode = 0;

    // Empty packet on engine 1.
    step(); step(); step();
    @(negedge clk);
    avail[1] = 1'b1;
    #3;
    step();
    chk("t4_valid_c1", 64'(tx_valid), 64'd0);
    step();
    chk("t4_pread_c2", {56'd0, tx_valid, 3'd0, pkt_read}, 64'h2);
    chk("t4_drops", 64'(drops), STATS ? 64'd1 : 64'd0);
    step();
    chk("t4_pread_c3", 64'(pkt_read), 64'd0);
    pr_q.delete();

    // Reset after 2 of 6 words.
    step(); step();
    @(negedge clk);
    load(0, 6, 4'd8, 8'hFF);
    acc0 = accepted;
    #3;
    n = 0;
    while (accepted - acc0 < 2 && n < 50) begin
      step();
      n++;
    end
    chk("t5_two_sent", 64'(accepted - acc0), 64'd2);
    @(negedge clk);
    ready_mode = 2;
    tx_ready   = 1'b0;
    areset     = 1'b1;
    #3;
    step();
    chk("t5_rst_ctrl", {61'd0, tx_valid, tx_last, busy}, 64'd0);
    chk("t5_rst_data", {tx_data[63:8], tx_mask}, 64'd0);
    chk("t5_rst_strobes", {56'd0, rd_en, pkt_read}, 64'd0);
    chk("t5_rst_counters", {sent, drops, 16'd0}, 64'd0);
    chk("t5_no_pread", 64'(pr_q.size()), 64'd0);
    step(); step();
    @(negedge clk);
    eng_q[0].delete();
    sb.delete();
    load(0, 6, 4'd8, 8'hFF);
    areset     = 1'b0;
    ready_mode = 0;
    tx_ready   = 1'b1;
    reads      = 0;
    accepted   = 0;
    #3;
    wait_pr(0, "t5_resend0");
    chk("t5_sb_drained", 64'(sb.size()), 64'd0);

    // Table of single packets across engines and last-word byte counts.
    for (int i = 0; i < 10; i++) begin
      step(); step();
      @(negedge clk);
      load(tbl[i].eng, tbl[i].nw, tbl[i].b, tbl[i].m);
      #3;
      wait_pr(tbl[i].eng, "tbl_pread");
    end
    step(); step(); step();
    chk("tbl_sb_drained", 64'(sb.size()), 64'd0);
    chk("tbl_sent", 64'(sent), STATS ? 64'd11 : 64'd0);
    chk("tbl_drops", 64'(drops), 64'd0);
    chk("tbl_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
